axi_perf_window_monitor: RTL

- Synthesizable, passive AXI4 performance monitor. It is the next generation of the file-logging bus monitors.
- It taps one AXI4 interface without driving it. It accumulates transaction, beat, byte, stall and latency statistics over either a programmable cycle window or manually delimited intervals.
- Each completed interval is published as a register snapshot with a one-cycle valid strobe, for on-chip NoC performance analysis by a collector or APB register block.

---
 rtl/axi_perf_window_monitor.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_perf_window_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axi_perf_window_monitor
// Purpose  : Passive AXI4 performance monitor. It taps the handshakes of one
//            AXI4 interface and accumulates transaction, beat, byte, stall and
//            latency-occupancy statistics. It accumulates over a programmable
//            cycle window (windowed mode) or between manual_snap pulses
//            (manual mode). Each closed interval is published as a snapshot
//            with a one-cycle snap_valid strobe.
// Ports    : ACLK/ARESET      - clock, asynchronous active-high reset
//            cfg_*            - enable, mode, window length, clear pulse
//            manual_snap      - closes the interval in manual mode
//            aw/w/b/ar/r      - observed valid/ready/last handshakes, wstrb
//            snap_*           - snapshot counters, saturation flag, strobe
//            wr/rd_outstanding- live outstanding transaction counts
//            err_overflow/err_underflow - sticky outstanding-counter errors
// Revision : 1.0 - initial release
// ============================================================================
module axi_perf_window_monitor #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int WIN_WIDTH  = 24,
    parameter int OST_WIDTH  = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    cfg_enable,
    input  logic                    cfg_mode,
    input  logic [WIN_WIDTH-1:0]    cfg_window,
    input  logic                    cfg_clear,
    input  logic                    manual_snap,
    input  logic                    awvalid,
    input  logic                    awready,
    input  logic                    wvalid,
    input  logic                    wready,
    input  logic                    wlast,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    bvalid,
    input  logic                    bready,
    input  logic                    arvalid,
    input  logic                    arready,
    input  logic                    rvalid,
    input  logic                    rready,
    input  logic                    rlast,
    output logic                    snap_valid,
    output logic [CNT_WIDTH-1:0]    snap_cycles,
    output logic [CNT_WIDTH-1:0]    snap_wr_txn,
    output logic [CNT_WIDTH-1:0]    snap_rd_txn,
    output logic [CNT_WIDTH-1:0]    snap_wr_beats,
    output logic [CNT_WIDTH-1:0]    snap_rd_beats,
    output logic [CNT_WIDTH-1:0]    snap_wr_bytes,
    output logic [CNT_WIDTH-1:0]    snap_wr_lat_sum,
    output logic [CNT_WIDTH-1:0]    snap_rd_lat_sum,
    output logic [CNT_WIDTH-1:0]    snap_aw_stall,
    output logic [CNT_WIDTH-1:0]    snap_ar_stall,
    output logic                    snap_sat,
    output logic [OST_WIDTH-1:0]    wr_outstanding,
    output logic [OST_WIDTH-1:0]    rd_outstanding,
    output logic                    err_overflow,
    output logic                    err_underflow
);

    localparam int c_strb_w       = DATA_WIDTH / 8;
    localparam int c_unused_id_w  = ID_WIDTH;   // IDs are not needed for occupancy counting
    localparam int c_num_acc      = 10;

    // Accumulator / snapshot slot indices
    localparam int c_cyc      = 0;
    localparam int c_wr_txn   = 1;
    localparam int c_rd_txn   = 2;
    localparam int c_wr_beats = 3;
    localparam int c_rd_beats = 4;
    localparam int c_wr_bytes = 5;
    localparam int c_wr_lat   = 6;
    localparam int c_rd_lat   = 7;
    localparam int c_aw_stall = 8;
    localparam int c_ar_stall = 9;

    localparam logic [0:0]           c_idle    = 1'b0;
    localparam logic [0:0]           c_run     = 1'b1;
    localparam logic [WIN_WIDTH-1:0] c_win_one = WIN_WIDTH'(1);

    logic [0:0]           r_state;
    logic [CNT_WIDTH-1:0] r_acc  [c_num_acc];
    logic [CNT_WIDTH-1:0] r_snap [c_num_acc];
    logic [CNT_WIDTH-1:0] w_inc  [c_num_acc];
    logic [CNT_WIDTH-1:0] w_sum  [c_num_acc];
    logic [c_num_acc-1:0] w_ovf;
    logic [CNT_WIDTH-1:0] w_popcnt;
    logic [WIN_WIDTH-1:0] r_win_cnt;
    logic [WIN_WIDTH-1:0] r_win_len;
    logic                 r_sat;
    logic                 r_snap_sat;
    logic                 r_snap_valid;
    logic [OST_WIDTH-1:0] r_wr_ost;
    logic [OST_WIDTH-1:0] r_rd_ost;
    logic                 r_err_ovf;
    logic                 r_err_unf;
    logic                 w_unused;

    assign w_unused = wlast;

    wire w_aw_fire = awvalid & awready;
    wire w_w_fire  = wvalid  & wready;
    wire w_b_fire  = bvalid  & bready;
    wire w_ar_fire = arvalid & arready;
    wire w_r_fire  = rvalid  & rready;
    wire w_r_last  = w_r_fire & rlast;
    wire w_run     = (r_state == c_run);

    // Window length is latched so that a cfg_window change only applies from
    // the next boundary or clear; while idle it tracks the config directly.
    wire w_win_hit  = (r_win_len != '0) && (r_win_cnt == (r_win_len - c_win_one));
    wire w_boundary = w_run && (cfg_mode ? manual_snap : w_win_hit);

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < c_strb_w; i++) begin
            w_popcnt = w_popcnt + CNT_WIDTH'(wstrb[i]);
        end
    end

    always_comb begin
        w_inc[c_cyc]      = CNT_WIDTH'(1'b1);
        w_inc[c_wr_txn]   = CNT_WIDTH'(w_aw_fire);
        w_inc[c_rd_txn]   = CNT_WIDTH'(w_ar_fire);
        w_inc[c_wr_beats] = CNT_WIDTH'(w_w_fire);
        w_inc[c_rd_beats] = CNT_WIDTH'(w_r_fire);
        w_inc[c_wr_bytes] = w_w_fire ? w_popcnt : '0;
        // Occupancy integral: summing the pre-update outstanding count each
        // cycle gives total latency regardless of response ordering.
        w_inc[c_wr_lat]   = CNT_WIDTH'(r_wr_ost);
        w_inc[c_rd_lat]   = CNT_WIDTH'(r_rd_ost);
        w_inc[c_aw_stall] = CNT_WIDTH'(awvalid & ~awready);
        w_inc[c_ar_stall] = CNT_WIDTH'(arvalid & ~arready);
    end

    // Saturating add of this cycle's events onto every accumulator
    always_comb begin
        w_ovf = '0;
        for (int i = 0; i < c_num_acc; i++) begin
            {w_ovf[i], w_sum[i]} = {1'b0, r_acc[i]} + {1'b0, w_inc[i]};
            if (w_ovf[i]) begin
                w_sum[i] = '1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= c_idle;
        end else begin
            case (r_state)
                c_idle:  if (cfg_enable)  r_state <= c_run;
                c_run:   if (!cfg_enable) r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < c_num_acc; i++) begin
                r_acc[i]  <= '0;
                r_snap[i] <= '0;
            end
            r_win_cnt    <= '0;
            r_win_len    <= '0;
            r_sat        <= 1'b0;
            r_snap_sat   <= 1'b0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= w_boundary;
            if (!w_run || w_boundary || cfg_clear) begin
                r_win_len <= cfg_window;
            end
            // Boundary wins over cfg_clear; both start the next interval at 0.
            if (w_boundary) begin
                for (int i = 0; i < c_num_acc; i++) begin
                    r_snap[i] <= w_sum[i];
                    r_acc[i]  <= '0;
                end
                r_snap_sat <= r_sat | (|w_ovf);
                r_sat      <= 1'b0;
                r_win_cnt  <= '0;
            end else if (cfg_clear) begin
                for (int i = 0; i < c_num_acc; i++) begin
                    r_acc[i] <= '0;
                end
                r_sat     <= 1'b0;
                r_win_cnt <= '0;
            end else if (w_run) begin
                for (int i = 0; i < c_num_acc; i++) begin
                    r_acc[i] <= w_sum[i];
                end
                r_sat     <= r_sat | (|w_ovf);
                r_win_cnt <= r_win_cnt + c_win_one;
            end
        end
    end

    // Outstanding counters track in every state to stay coherent with the bus.
    // Simultaneous increment and decrement cancel and can never flag an error.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_ost  <= '0;
            r_rd_ost  <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (w_aw_fire && !w_b_fire) begin
                if (&r_wr_ost) r_err_ovf <= 1'b1;
                else           r_wr_ost  <= r_wr_ost + 1'b1;
            end else if (w_b_fire && !w_aw_fire) begin
                if (r_wr_ost == '0) r_err_unf <= 1'b1;
                else                r_wr_ost  <= r_wr_ost - 1'b1;
            end
            if (w_ar_fire && !w_r_last) begin
                if (&r_rd_ost) r_err_ovf <= 1'b1;
                else           r_rd_ost  <= r_rd_ost + 1'b1;
            end else if (w_r_last && !w_ar_fire) begin
                if (r_rd_ost == '0) r_err_unf <= 1'b1;
                else                r_rd_ost  <= r_rd_ost - 1'b1;
            end
        end
    end

    assign snap_valid      = r_snap_valid;
    assign snap_cycles     = r_snap[c_cyc];
    assign snap_wr_txn     = r_snap[c_wr_txn];
    assign snap_rd_txn     = r_snap[c_rd_txn];
    assign snap_wr_beats   = r_snap[c_wr_beats];
    assign snap_rd_beats   = r_snap[c_rd_beats];
    assign snap_wr_bytes   = r_snap[c_wr_bytes];
    assign snap_wr_lat_sum = r_snap[c_wr_lat];
    assign snap_rd_lat_sum = r_snap[c_rd_lat];
    assign snap_aw_stall   = r_snap[c_aw_stall];
    assign snap_ar_stall   = r_snap[c_ar_stall];
    assign snap_sat        = r_snap_sat;
    assign wr_outstanding  = r_wr_ost;
    assign rd_outstanding  = r_rd_ost;
    assign err_overflow    = r_err_ovf;
    assign err_underflow   = r_err_unf;

endmodule
`default_nettype wire
